// File: rtl/display_scan.sv
// Multiplexed 7-segment scanner: captures a hex value, lights one digit per slot.
// Optional build macro LEADING_ZERO_BLANK_EN darkens leading zero digits.
module display_scan #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 50000
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Load,
    input  logic [4*NDIG-1:0] Valor,
    output logic [3:0]        Nibble,
    output logic [NDIG-1:0]   DigitoEn,
    output logic              FrameDone
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [4*NDIG-1:0] r_shadow;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [3:0]        r_nib;
    logic [NDIG-1:0]   r_en;
    logic              r_fd;

    logic              w_tick;
    logic [IW-1:0]     w_idx_next;
    logic [3:0]        w_nib_next;
    logic [NDIG-1:0]   w_en_next;
    logic              w_blank;

`ifdef LEADING_ZERO_BLANK_EN
    // w_zero_from[i]: every shadow nibble from digit i upward is zero
    logic [NDIG-1:0]   w_zero_from;

    always_comb begin
        w_zero_from = '0;
        for (int i = 0; i < NDIG; i++) begin
            w_zero_from[i] = ~|(r_shadow >> (4 * i));
        end
    end

    assign w_blank = (w_idx_next != '0) && w_zero_from[w_idx_next];
`else
    assign w_blank = 1'b0;
`endif

    assign w_tick = (r_cnt == CNT_MAX);

    always_comb begin
        w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        w_nib_next = r_shadow[4*w_idx_next +: 4];
        w_en_next  = '1;
        w_en_next[w_idx_next] = 1'b0;
        if (w_blank) begin
            w_nib_next = 4'h0;
            w_en_next  = '1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_idx    <= IDX_LAST;
            r_nib    <= 4'h0;
            r_en     <= '1;
            r_fd     <= 1'b0;
        end else begin
            if (Load) begin
                r_shadow <= Valor;
            end
            r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
            r_fd  <= 1'b0;
            // slot boundary reads the shadow before any same-edge Load
            if (w_tick) begin
                r_idx <= w_idx_next;
                r_nib <= w_nib_next;
                r_en  <= w_en_next;
                r_fd  <= (w_idx_next == IDX_LAST);
            end
        end
    end

    assign Nibble    = r_nib;
    assign DigitoEn  = r_en;
    assign FrameDone = r_fd;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan (NDIG=4, PRESCALE=4): tables,
// hand sequences and random traffic against a slot-arithmetic model.
module tb_display_scan;

    localparam int NDIG = 4;
    localparam int P    = 4;

    logic        Clock  = 1'b0;
    logic        Resetn = 1'b0;
    logic        Load   = 1'b0;
    logic [15:0] Valor  = '0;
    logic [3:0]  Nibble;
    logic [3:0]  DigitoEn;
    logic        FrameDone;

    display_scan #(.NDIG(NDIG), .PRESCALE(P)) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .Load(Load),
        .Valor(Valor),
        .Nibble(Nibble),
        .DigitoEn(DigitoEn),
        .FrameDone(FrameDone)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // model: edges since reset release, shadow, value/digit latched at last boundary
    int          n;
    logic [15:0] m_shadow;
    logic [15:0] m_disp;
    int          m_digit;

    typedef struct {
        logic [15:0] v;
        logic [15:0] nibs;
        logic [15:0] ens;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s n=%0d actual=%h required=%h", name, n, act, exp);
        end
    endtask

    function automatic logic [8:0] model_out();
        logic [3:0] nb;
        logic [3:0] en;
        logic       fd;
        if (n < P) return {4'h0, 4'hF, 1'b0};
        nb = m_disp[4*m_digit +: 4];
        en = ~(4'b0001 << m_digit);
        fd = (n % P == 0) && (m_digit == NDIG - 1);
`ifdef LEADING_ZERO_BLANK_EN
        if (m_digit > 0 && (m_disp >> (4 * m_digit)) == 16'h0) begin
            nb = 4'h0;
            en = 4'hF;
        end
`endif
        return {nb, en, fd};
    endfunction

    task automatic cyc(input logic ld, input logic [15:0] v);
        Load  = ld;
        Valor = v;
        @(posedge Clock);
        n++;
        if (n >= P && n % P == 0) begin
            m_disp  = m_shadow;
            m_digit = (n / P - 1) % NDIG;
        end
        if (ld) m_shadow = v;
        #1;
        chk("model", {23'd0, Nibble, DigitoEn, FrameDone}, {23'd0, model_out()});
        Load = 1'b0;
    endtask

    task automatic model_clear();
        n        = 0;
        m_shadow = '0;
        m_disp   = '0;
        m_digit  = 0;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        Load   = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_state", {23'd0, Nibble, DigitoEn, FrameDone},
            {23'd0, 4'h0, 4'hF, 1'b0});
        Resetn = 1'b1;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog n=%0d", n);
        $fatal(1);
    end

    initial begin
        int d;
        int fd_cnt;
        int fd_first;
        int fd_last;
        logic [15:0] rv;

        model_clear();
        tbl[0] = '{16'h1A3F, 16'h1A3F, 16'h7BDE};
`ifdef LEADING_ZERO_BLANK_EN
        tbl[1] = '{16'h0005, 16'h0005, 16'hFFFE};
        tbl[2] = '{16'h0000, 16'h0000, 16'hFFFE};
        tbl[3] = '{16'h0100, 16'h0100, 16'hFBDE};
`else
        tbl[1] = '{16'h0005, 16'h0005, 16'h7BDE};
        tbl[2] = '{16'h0000, 16'h0000, 16'h7BDE};
        tbl[3] = '{16'h0100, 16'h0100, 16'h7BDE};
`endif
        tbl[4] = '{16'hBEEF, 16'hBEEF, 16'h7BDE};

        // reset release with no Load: blank slot then zeros
        do_reset();
        while (n < 5 * P) begin
            cyc(1'b0, 16'h0);
            if (n == P) chk("first_slot", {28'd0, DigitoEn}, 32'hE);
        end

        // table rows: each digit's slot against hand-written constants
        foreach (tbl[r]) begin
            do_reset();
            cyc(1'b1, tbl[r].v);
            while (n < 5 * P) begin
                cyc(1'b0, 16'h0);
                if (n >= P) begin
                    d = (n / P - 1) % NDIG;
                    chk("table_nib", {28'd0, Nibble}, {28'd0, tbl[r].nibs[4*d +: 4]});
                    chk("table_en", {28'd0, DigitoEn}, {28'd0, tbl[r].ens[4*d +: 4]});
                end
            end
        end

        // FrameDone period
        do_reset();
        cyc(1'b1, 16'h1A3F);
        fd_cnt   = 0;
        fd_first = -1;
        fd_last  = -1;
        repeat (64) begin
            cyc(1'b0, 16'h0);
            if (FrameDone) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = n;
                fd_last = n;
            end
        end
        chk("fd_count", fd_cnt, 4);
        chk("fd_first", fd_first, 16);
        chk("fd_span", fd_last - fd_first, 48);

        // Load on the boundary edge that selects digit 2
        do_reset();
        cyc(1'b1, 16'h1A3F);
        cyc(1'b1, 16'h0000);
        while (n < 11) cyc(1'b0, 16'h0);
        cyc(1'b1, 16'hBEEF);
        chk("same_edge_nib", {28'd0, Nibble}, 32'h0);
`ifdef LEADING_ZERO_BLANK_EN
        chk("same_edge_en", {28'd0, DigitoEn}, 32'hF);
`else
        chk("same_edge_en", {28'd0, DigitoEn}, 32'hB);
`endif
        while (n < 16) cyc(1'b0, 16'h0);
        chk("next_slot", {23'd0, Nibble, DigitoEn, FrameDone}, {23'd0, 4'hB, 4'h7, 1'b1});
        while (n < 20) cyc(1'b0, 16'h0);
        chk("wrap_slot", {23'd0, Nibble, DigitoEn, FrameDone}, {23'd0, 4'hF, 4'hE, 1'b0});

        // asynchronous reset mid-slot of digit 2
        do_reset();
        cyc(1'b1, 16'h1A3F);
        while (n < 13) cyc(1'b0, 16'h0);
        chk("pre_async", {28'd0, DigitoEn}, 32'hB);
        #2;
        Resetn = 1'b0;
        #1;
        chk("async_rst", {23'd0, Nibble, DigitoEn, FrameDone}, {23'd0, 4'h0, 4'hF, 1'b0});
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        model_clear();
        while (n < 2 * P) begin
            cyc(1'b0, 16'h0);
            if (n == P - 1) chk("post_blank", {28'd0, DigitoEn}, 32'hF);
            if (n == P) chk("post_dig0", {28'd0, Nibble, DigitoEn}, 32'h0E);
        end

        // random traffic against the model
        do_reset();
        repeat (400) begin
            rv = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rv = rv & 16'h000F;
                1: rv = rv & 16'h00FF;
                2: rv = rv & 16'h0F0F;
                default: ;
            endcase
            cyc($urandom_range(0, 5) == 0, rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
